wbit_alu_seq: RTL and testbench
===============================

# wbit_alu_seq

Parametrised, handshaked successor to the team's combinational W-bit ALU. It keeps the eight basic ops with NZCV semantics and adds carry-in arithmetic, iterative shifts, an iterative multiply, compare and move, all behind a valid/ready interface. Flags live in a register and update only when requested. It sits between operand fetch and writeback in the datapath; single-cycle ops sustain one result per cycle.

## Interface
- W, default 8: operand/result width, ≥ 4.
- S, derived as $clog2(W): shift-amount width, not overridable.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block accepts the operation. A transfer occurs when in_valid and in_ready are both high at a rising edge.
- in_a  in  W  operand A, two's complement.
- in_b  in  W  operand B. Bits B[S-1:0] are the shift amount for shift ops.
- in_op  in  4  operation code.
- in_setf  in  1  write the computed flags into nzcv when the op completes.
- out_valid  out  1  result is valid and is held until accepted.
- out_ready  in  1  consumer accepts the result.
- result  out  W  operation result.
- nzcv  out  4  flag register; [3]=N, [2]=Z, [1]=C, [0]=V.

## Operation
- Op codes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 RSB: B−A.
  - 3 BIC: A&~B.
  - 4 AND.
  - 5 ORR.
  - 6 EOR.
  - 7 XNOR.
  - 8 ADC: A+B+C.
  - 9 SBC: A−B−!C.
  - 10 LSL.
  - 11 LSR.
  - 12 ASR.
  - 13 MUL: low W bits of A×B, unsigned.
  - 14 CMP: computes SUB flags; result=A.
  - 15 MOV: result=B.
- C and V:
  - Arithmetic ops use W+1-bit sums. Subtraction is computed as X+~Y+1 and C is its carry-out, so C=1 means no borrow.
  - V is signed overflow: operands of equal sign give a sum of the opposite sign.
  - Logic ops and MOV clear C and V.
  - Shifts set C to the last bit shifted out and leave V unchanged. Shift amount 0 leaves C unchanged and gives result=A.
  - MUL leaves C and V unchanged.
- N and Z: always N=result[W−1] and Z=(result==0). For CMP they come from the difference, not from result.
- Flag write: when in_setf=0, nzcv is untouched. ADC and SBC read the registered C as it stood at the accept edge.
- FSM states:
  - IDLE → DONE on accept of a basic op, or of a shift with amount 0.
  - IDLE → BUSY on accept of MUL, or of a shift with nonzero amount.
  - BUSY does one iteration per cycle: one shift-add step for MUL, one bit position for shifts. It moves to DONE after the last iteration.
  - DONE → IDLE on out_ready with no new accept. DONE → DONE or BUSY on out_ready together with a new accept.
- in_ready = !rst_n ? 0 : (IDLE | (DONE & out_ready)). It is low throughout BUSY.
- result and nzcv are written at the edge that enters DONE. Both are stable while out_valid=1.

## Timing
- Latency L is counted from the handshake cycle to the first cycle with out_valid=1:
  - basic ops: L=1.
  - LSL, LSR, ASR: L=1+shamt.
  - MUL: L=1+W.
- Reset values: out_valid=0, result=0, nzcv=0, state=IDLE. in_ready is 0 while rst_n=0 and 1 in the first cycle after release.
- Reset asserted mid-BUSY or mid-DONE aborts the operation. No result is emitted.
- Back-to-back: in DONE with out_ready=1 and in_valid=1, the output and input handshakes occur on the same edge. A following basic op gives out_valid continuously high.
- out_valid=1 with out_ready=0 stalls indefinitely: result, nzcv and state are held and in_ready=0.
- Iterative counters and operand shadows are not visible on outputs and are don't-care in IDLE.

## Structure
- Package alu_pkg holds:
  - op_e enum with the 16 codes.
  - state_e enum: IDLE, BUSY, DONE.
  - flag bit indices: N_IDX, Z_IDX, C_IDX, V_IDX.
- Sub-module alu_iter_unit holds the MUL shift-add datapath and the shift datapath, including the iteration counter and the done pulse. The top level holds the FSM, the single-cycle ops and the flag register.

## Test plan
All scenarios run with W=8.
- ADD 0x7F+0x01 with setf=1 → result 0x80, nzcv=4'b1001, L=1. Repeat with setf=0 → nzcv unchanged.
- SUB 0x05−0x05 with setf → 0x00, nzcv=4'b0110. Then ADC 0x01+0x01 → 0x03. Then CMP 0x03,0x04 → result 0x03, nzcv=4'b1000.
- MUL 0x0D×0x0B → 0x8F. out_valid first high 9 cycles after the handshake; in_ready low throughout. nzcv=4'b10CV with C and V retained.
- LSR 0x81 by 3 → 0x10, C=0, L=4. ASR 0x81 by 1 → 0xC0, C=1, L=2. LSL by 0 → result=A, C unchanged, L=1.
- Hold out_ready=0 for 5 cycles with in_valid=1 → result held and in_ready=0. Then raise out_ready → both handshakes on one edge, and the next basic result appears the following cycle.
- Assert rst_n=0 during MUL iteration 4 → out_valid=0 and nzcv=0 immediately. After release, in_ready=1 and a new ADD completes with L=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential W-bit ALU.
//   op_e     : 4-bit operation codes
//   state_e  : control FSM states
//   *_IDX    : bit positions of N, Z, C, V inside the nzcv register
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_RSB  = 4'd2,
    OP_BIC  = 4'd3,
    OP_AND  = 4'd4,
    OP_ORR  = 4'd5,
    OP_EOR  = 4'd6,
    OP_XNOR = 4'd7,
    OP_ADC  = 4'd8,
    OP_SBC  = 4'd9,
    OP_LSL  = 4'd10,
    OP_LSR  = 4'd11,
    OP_ASR  = 4'd12,
    OP_MUL  = 4'd13,
    OP_CMP  = 4'd14,
    OP_MOV  = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int N_IDX = 3;
  localparam int Z_IDX = 2;
  localparam int C_IDX = 1;
  localparam int V_IDX = 0;

  function automatic logic is_shift(op_e op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Multi-cycle datapath: shift-add multiplier and one-bit-per-cycle shifter.
//   clk, rst_n : clock, async active-low reset
//   start      : load operands and begin (op is MUL or a shift with amount != 0)
//   start_op   : operation being started
//   a, b       : operands; b[S-1:0] is the shift amount, b is the multiplier
//   done       : high during the last iteration cycle
//   res        : value after the current iteration (valid with done)
//   c_out      : bit shifted out in the current iteration (shifts only)
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  op_e          start_op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] res,
  output logic         c_out
);

  localparam int S = $clog2(W);

  op_e          op_q;
  logic [S:0]   cnt;     // iterations still to run, 0 = inactive
  logic [W-1:0] acc;     // MUL partial product
  logic [W-1:0] opnd;    // MUL multiplicand (shifts left) or shift value
  logic [W-1:0] mplier;  // MUL multiplier (shifts right)
  logic [W-1:0] step_res;
  logic         step_c;

  always_comb begin
    step_res = opnd;
    step_c   = 1'b0;
    case (op_q)
      OP_MUL: step_res = acc + (mplier[0] ? opnd : '0);
      OP_LSL: begin
        step_res = {opnd[W-2:0], 1'b0};
        step_c   = opnd[W-1];
      end
      OP_LSR: begin
        step_res = {1'b0, opnd[W-1:1]};
        step_c   = opnd[0];
      end
      default: begin
        step_res = {opnd[W-1], opnd[W-1:1]};
        step_c   = opnd[0];
      end
    endcase
  end

  assign done  = (cnt == (S+1)'(1));
  assign res   = step_res;
  assign c_out = step_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= OP_MUL;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      mplier <= '0;
    end else if (start) begin
      op_q   <= start_op;
      cnt    <= (start_op == OP_MUL) ? (S+1)'(W) : {1'b0, b[S-1:0]};
      acc    <= '0;
      opnd   <= a;
      mplier <= b;
    end else if (cnt != '0) begin
      cnt <= cnt - (S+1)'(1);
      if (op_q == OP_MUL) begin
        acc    <= step_res;
        opnd   <= {opnd[W-2:0], 1'b0};
        mplier <= {1'b0, mplier[W-1:1]};
      end else begin
        opnd <= step_res;
      end
    end
  end

endmodule

// File: rtl/wbit_alu_seq.sv
// Handshaked W-bit ALU with registered NZCV flags.
// Single-cycle ops complete in one cycle; MUL and nonzero shifts iterate
// in alu_iter_unit while the FSM sits in BUSY.
//   clk, rst_n           : clock, async active-low reset
//   in_valid / in_ready  : operation handshake
//   in_a, in_b, in_op    : operands and op code
//   in_setf              : update nzcv when this op completes
//   out_valid / out_ready: result handshake
//   result, nzcv         : registered result and flags ({N,Z,C,V})
module wbit_alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [3:0]   in_op,
  input  logic         in_setf,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [3:0]   nzcv
);

  localparam int S = $clog2(W);

  state_e       state;
  op_e          op;
  logic         accept, go_iter;
  logic         setf_q, mul_q;

  // single-cycle path
  logic [W-1:0] x, y;
  logic         cin;
  logic [W:0]   sum;
  logic         v_ar;
  logic [W-1:0] b_res, flag_src;
  logic         b_c, b_v;
  logic [3:0]   b_nzcv;

  // iterative path
  logic         it_done, it_c;
  logic [W-1:0] it_res;
  logic [3:0]   it_nzcv;

  assign op        = op_e'(in_op);
  assign in_ready  = rst_n & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign go_iter   = accept & ((op == OP_MUL) | (is_shift(op) & (in_b[S-1:0] != '0)));
  assign out_valid = (state == DONE);

  // Every arithmetic op is x + y + cin; subtraction pre-inverts y so the
  // carry-out reads as "no borrow".
  always_comb begin
    x   = in_a;
    y   = ~in_b;
    cin = 1'b1;
    case (op)
      OP_ADD: begin y = in_b; cin = 1'b0;       end
      OP_ADC: begin y = in_b; cin = nzcv[C_IDX]; end
      OP_SBC: cin = nzcv[C_IDX];
      OP_RSB: begin x = in_b; y = ~in_a;        end
      default: ;
    endcase
  end

  assign sum  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
  assign v_ar = (x[W-1] == y[W-1]) & (sum[W-1] != x[W-1]);

  always_comb begin
    b_res = sum[W-1:0];
    b_c   = sum[W];
    b_v   = v_ar;
    case (op)
      OP_CMP:  b_res = in_a;
      OP_BIC:  begin b_res = in_a & ~in_b;   b_c = 1'b0; b_v = 1'b0; end
      OP_AND:  begin b_res = in_a & in_b;    b_c = 1'b0; b_v = 1'b0; end
      OP_ORR:  begin b_res = in_a | in_b;    b_c = 1'b0; b_v = 1'b0; end
      OP_EOR:  begin b_res = in_a ^ in_b;    b_c = 1'b0; b_v = 1'b0; end
      OP_XNOR: begin b_res = ~(in_a ^ in_b); b_c = 1'b0; b_v = 1'b0; end
      OP_MOV:  begin b_res = in_b;           b_c = 1'b0; b_v = 1'b0; end
      // only zero-amount shifts take this path
      OP_LSL, OP_LSR, OP_ASR, OP_MUL: begin
        b_res = in_a;
        b_c   = nzcv[C_IDX];
        b_v   = nzcv[V_IDX];
      end
      default: ;
    endcase
  end

  // CMP reports N/Z of the difference while result carries A through
  assign flag_src = (op == OP_CMP) ? sum[W-1:0] : b_res;
  assign b_nzcv   = {flag_src[W-1], flag_src == '0, b_c, b_v};

  // nzcv cannot change while BUSY, so the live register supplies retained bits
  assign it_nzcv = {it_res[W-1], it_res == '0,
                    mul_q ? nzcv[C_IDX] : it_c, nzcv[V_IDX]};

  alu_iter_unit #(.W(W)) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (go_iter),
    .start_op (op),
    .a        (in_a),
    .b        (in_b),
    .done     (it_done),
    .res      (it_res),
    .c_out    (it_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      nzcv   <= '0;
      setf_q <= 1'b0;
      mul_q  <= 1'b0;
    end else if (accept) begin
      setf_q <= in_setf;
      mul_q  <= (op == OP_MUL);
      if (go_iter) begin
        state <= BUSY;
      end else begin
        state  <= DONE;
        result <= b_res;
        if (in_setf) nzcv <= b_nzcv;
      end
    end else if ((state == BUSY) && it_done) begin
      state  <= DONE;
      result <= it_res;
      if (setf_q) nzcv <= it_nzcv;
    end else if ((state == DONE) && out_ready) begin
      state <= IDLE;
    end
  end

endmodule

// File: tb/tb_wbit_alu_seq.sv
module tb_wbit_alu_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] in_op = '0;
  logic       in_setf = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result;
  logic [3:0] nzcv;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wbit_alu_seq #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_setf(in_setf),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .nzcv(nzcv)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       setf;
    logic [7:0] res;
    logic [3:0] fl;
    int         lat;
  } vec_t;

  vec_t vt[25];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  // Issues one op with out_ready=1, measures latency and checks the result.
  task automatic do_op(input int idx, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic setf, input logic [7:0] er,
                       input logic [3:0] ef, input int el);
    int lat, w;
    logic busy_rdy;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_setf = setf;
    in_valid = 1'b1; out_ready = 1'b1;
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    chk("accept_ready", idx, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; busy_rdy = 1'b0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", idx, lat, el);
    chk("result", idx, {24'd0, result}, {24'd0, er});
    chk("nzcv", idx, {28'd0, nzcv}, {28'd0, ef});
    if (el > 1) chk("busy_in_ready", idx, {31'd0, busy_rdy}, 32'd0);
  endtask

  initial begin
    vt[0]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 1};  // ADD overflow
    vt[1]  = '{4'd0,  8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001, 1};  // setf=0
    vt[2]  = '{4'd1,  8'h05, 8'h05, 1'b1, 8'h00, 4'b0110, 1};  // SUB zero
    vt[3]  = '{4'd13, 8'h0D, 8'h0B, 1'b1, 8'h8F, 4'b1010, 9};  // MUL keeps C=1
    vt[4]  = '{4'd8,  8'h01, 8'h01, 1'b1, 8'h03, 4'b0000, 1};  // ADC with C=1
    vt[5]  = '{4'd14, 8'h03, 8'h04, 1'b1, 8'h03, 4'b1000, 1};  // CMP
    vt[6]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 1};
    vt[7]  = '{4'd13, 8'h0D, 8'h0B, 1'b1, 8'h8F, 4'b1001, 9};  // MUL keeps V=1
    vt[8]  = '{4'd11, 8'h81, 8'h03, 1'b1, 8'h10, 4'b0001, 4};  // LSR 3
    vt[9]  = '{4'd12, 8'h81, 8'h01, 1'b1, 8'hC0, 4'b1011, 2};  // ASR 1
    vt[10] = '{4'd10, 8'h5A, 8'h00, 1'b1, 8'h5A, 4'b0011, 1};  // LSL 0
    vt[11] = '{4'd9,  8'h05, 8'h03, 1'b1, 8'h02, 4'b0010, 1};  // SBC C=1
    vt[12] = '{4'd1,  8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 1};  // SUB borrow
    vt[13] = '{4'd9,  8'h05, 8'h03, 1'b1, 8'h01, 4'b0010, 1};  // SBC C=0
    vt[14] = '{4'd2,  8'h03, 8'h05, 1'b1, 8'h02, 4'b0010, 1};  // RSB
    vt[15] = '{4'd3,  8'hF0, 8'h30, 1'b1, 8'hC0, 4'b1000, 1};  // BIC
    vt[16] = '{4'd4,  8'h0F, 8'hF0, 1'b1, 8'h00, 4'b0100, 1};  // AND
    vt[17] = '{4'd5,  8'h0F, 8'h30, 1'b1, 8'h3F, 4'b0000, 1};  // ORR
    vt[18] = '{4'd6,  8'hFF, 8'h0F, 1'b1, 8'hF0, 4'b1000, 1};  // EOR
    vt[19] = '{4'd7,  8'h0F, 8'h0F, 1'b1, 8'hFF, 4'b1000, 1};  // XNOR
    vt[20] = '{4'd15, 8'h11, 8'h00, 1'b1, 8'h00, 4'b0100, 1};  // MOV
    vt[21] = '{4'd10, 8'h81, 8'h01, 1'b1, 8'h02, 4'b0010, 2};  // LSL 1
    vt[22] = '{4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 4'b0110, 1};  // ADD carry
    vt[23] = '{4'd8,  8'h00, 8'h00, 1'b1, 8'h01, 4'b0000, 1};  // ADC carry in
    vt[24] = '{4'd1,  8'h03, 8'h05, 1'b1, 8'hFE, 4'b1000, 1};

    // reset state
    #12;
    chk("rst_in_ready", 0, {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("rst_result", 0, {24'd0, result}, 32'd0);
    chk("rst_nzcv", 0, {28'd0, nzcv}, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("rel_in_ready", 0, {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 25; i++)
      do_op(i, vt[i].op, vt[i].a, vt[i].b, vt[i].setf, vt[i].res, vt[i].fl, vt[i].lat);

    // drain to IDLE
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drain_out_valid", 0, {31'd0, out_valid}, 32'd0);

    // output stall with a pending input, then both handshakes on one edge
    @(negedge clk);
    in_op = 4'd0; in_a = 8'h10; in_b = 8'h20; in_setf = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_a = 8'h01; in_b = 8'h02;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_valid", c, {31'd0, out_valid}, 32'd1);
      chk("stall_result", c, {24'd0, result}, 32'h30);
      chk("stall_in_ready", c, {31'd0, in_ready}, 32'd0);
      chk("stall_nzcv", c, {28'd0, nzcv}, 32'b1000);
    end
    out_ready = 1'b1; #1;
    chk("b2b_in_ready", 0, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", 0, {31'd0, out_valid}, 32'd1);
    chk("b2b_result", 0, {24'd0, result}, 32'h03);
    @(posedge clk); #1;
    chk("b2b_drain", 0, {31'd0, out_valid}, 32'd0);

    // reset during MUL iteration 4
    @(negedge clk);
    in_op = 4'd13; in_a = 8'h0D; in_b = 8'h0B; in_setf = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mul_busy_ready", 0, {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0; #1;
    chk("abort_out_valid", 0, {31'd0, out_valid}, 32'd0);
    chk("abort_nzcv", 0, {28'd0, nzcv}, 32'd0);
    chk("abort_in_ready", 0, {31'd0, in_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("rerel_in_ready", 0, {31'd0, in_ready}, 32'd1);
    chk("rerel_out_valid", 0, {31'd0, out_valid}, 32'd0);
    do_op(100, 4'd0, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b1001, 1);
    // aborted MUL must never surface
    @(posedge clk); #1;
    chk("no_ghost", 0, {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
